// File: rtl/pulse_generator_pkg.sv
// Shared types and default sizing for the pulse-train generator and its channels.
package pulse_generator_pkg;

  typedef enum logic [1:0] {PT_IDLE, PT_DELAY, PT_HIGH, PT_LOW} pt_state_t;

  localparam int PT_NUM_CH      = 2;
  localparam int PT_CNT_W       = 8;
  localparam int PT_RESET_DELAY = 3;

endpackage

// File: rtl/pulse_train_channel.sv
// One independent pulse-train channel: latches its config at start, then runs
// DELAY -> HIGH <-> LOW until the programmed number of pulses has been emitted.
module pulse_train_channel
  import pulse_generator_pkg::*;
#(
  parameter int CNT_W = PT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ready,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  // Handshake: start is a level; it is taken at a clock edge only when the
  // channel is IDLE, ready is 1 and abort is 0. Otherwise it is dropped.

  pt_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] w_m1_q, w_m1_d;
  logic [CNT_W-1:0] low_m1_q, low_m1_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] width_c;
  logic [CNT_W-1:0] count_c;
  logic [CNT_W-1:0] low_c;

  // Clamps: period <= width is raised to width+1, so the low phase is
  // computed directly and never needs a (CNT_W+1)-bit period.
  always_comb begin
    width_c = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
    count_c = (cfg_count == '0) ? CNT_W'(1) : cfg_count;
    low_c   = (cfg_period > width_c) ? (cfg_period - width_c - CNT_W'(1)) : '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    w_m1_d   = w_m1_q;
    low_m1_d = low_m1_q;
    pulse_d  = pulse_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      PT_IDLE: begin
        if (start && ready && !abort) begin
          state_d  = PT_DELAY;
          cnt_d    = cfg_delay;
          pcnt_d   = count_c - CNT_W'(1);
          w_m1_d   = width_c - CNT_W'(1);
          low_m1_d = low_c;
          busy_d   = 1'b1;
        end
      end
      PT_DELAY: begin
        if (cnt_q == '0) begin
          state_d = PT_HIGH;
          pulse_d = 1'b1;
          cnt_d   = w_m1_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PT_HIGH: begin
        if (cnt_q == '0) begin
          pulse_d = 1'b0;
          if (pcnt_q == '0) begin
            state_d = PT_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = PT_LOW;
            cnt_d   = low_m1_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PT_LOW: begin
        if (cnt_q == '0) begin
          state_d = PT_HIGH;
          pulse_d = 1'b1;
          cnt_d   = w_m1_q;
          pcnt_d  = pcnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = PT_IDLE;
    endcase
    // Abort overrides everything, including a completion on the same edge.
    if (abort && (state_q != PT_IDLE)) begin
      state_d = PT_IDLE;
      cnt_d   = '0;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PT_IDLE;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      w_m1_q   <= '0;
      low_m1_q <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      w_m1_q   <= w_m1_d;
      low_m1_q <= low_m1_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      assert (!pulse_q || busy_q) else $error("pulse_out high while not busy");
      assert (!(done_q && done_d)) else $error("done high two cycles in a row");
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_o   = state_q;

endmodule

// File: rtl/pulse_train_generator.sv
// Multi-channel pulse-train generator: a shared post-reset hold-off plus
// NUM_CH independent channels fed from slices of the cfg buses.
module pulse_train_generator
  import pulse_generator_pkg::*;
#(
  parameter int NUM_CH      = PT_NUM_CH,
  parameter int CNT_W       = PT_CNT_W,
  parameter int RESET_DELAY = PT_RESET_DELAY
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_count,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    ready,
  output logic [2*NUM_CH-1:0]     dbg_state
);

  localparam int HW = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;

  logic [HW-1:0] hold_q, hold_d;
  logic          ready_q, ready_d;

  always_comb begin
    hold_d  = hold_q;
    ready_d = ready_q;
    if (!ready_q) begin
      if (hold_q == '0) ready_d = 1'b1;
      else              hold_d  = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= HW'(RESET_DELAY - 1);
      ready_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_train_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .ready      (ready_q),
      .start      (start[i]),
      .abort      (abort[i]),
      .cfg_delay  (cfg_delay [i*CNT_W +: CNT_W]),
      .cfg_width  (cfg_width [i*CNT_W +: CNT_W]),
      .cfg_period (cfg_period[i*CNT_W +: CNT_W]),
      .cfg_count  (cfg_count [i*CNT_W +: CNT_W]),
      .pulse_out  (pulse_out[i]),
      .busy       (busy[i]),
      .done       (done[i]),
      .state_o    (dbg_state[2*i +: 2])
    );
  end

endmodule
